branch_predict_bht: RTL and testbench
=====================================

Name: branch_predict_bht

Overview:
- Parametrised dynamic branch predictor: a table of 2^INDEX_BITS saturating counters, each CNT_BITS wide.
- Lookup is combinational in IF, from PC and opcode. Update is registered, from the branch-resolution stage (EX).
- MODE selects indexing: bimodal (PC bits only) or gshare (PC XOR global history register).
- Supersedes the single-state 1-bit and 2-bit predictors. Adds per-PC tables, configurable counter width, global history and performance counters.

Parameters:
- INDEX_BITS, 4, log2 of table entries; range 1..10.
- CNT_BITS, 2, saturating counter width; range 1..4 (1 gives classic 1-bit behaviour).
- MODE, 0, 0 = bimodal, 1 = gshare.
- PERF_BITS, 16, width of performance counters.

Ports:
- clk, in, 1, clock.
- rst_n, in, 1, reset: synchronous, active-low.
- stall, in, 1, IF stage frozen.
- if_pc, in, 32, PC of instruction in IF.
- if_opcode, in, 6, opcode of instruction in IF.
- pred_taken, out, 1, prediction for the instruction in IF.
- pred_index, out, INDEX_BITS, table index used; carried down the pipeline to EX.
- upd_valid, in, 1, a branch resolved this cycle.
- upd_index, in, INDEX_BITS, pred_index carried with that branch.
- upd_taken, in, 1, actual outcome.
- upd_mispredict, in, 1, prediction was wrong (statistics only).
- perf_branches, out, PERF_BITS, resolved branch count.
- perf_mispredicts, out, PERF_BITS, mispredict count.

Behaviour:
- Branch opcodes: BEQ = 6'b000100, BNE = 6'b000101.
- Index:
  - MODE 0: idx = if_pc[INDEX_BITS+1:2].
  - MODE 1: idx = if_pc[INDEX_BITS+1:2] ^ ghr.
  - ghr is INDEX_BITS wide.
- pred_index = idx, combinational, always driven.
- pred_taken = MSB of cnt[idx] when if_opcode is BEQ/BNE and stall = 0; otherwise 0. Combinational; zero-cycle latency.
- Update, on a posedge with upd_valid = 1:
  - cnt[upd_index] increments if upd_taken, saturating at 2^CNT_BITS-1.
  - cnt[upd_index] decrements if not upd_taken, saturating at 0.
  - The update is not gated by stall. The EX stage guarantees one upd_valid pulse per branch.
- GHR (MODE 1 only):
  - On upd_valid, ghr <= {ghr[INDEX_BITS-2:0], upd_taken}. For INDEX_BITS = 1, ghr <= upd_taken.
  - Non-speculative: no repair logic needed.
  - In MODE 0, ghr is held at 0 and unused.
- Read/write same entry in the same cycle: the prediction uses the pre-update value. The new value is visible from the next cycle.
- Performance counters:
  - On upd_valid, perf_branches += 1.
  - On upd_valid with upd_mispredict, perf_mispredicts += 1.
  - Both saturate at all-ones; no wrap.
  - upd_mispredict is ignored when upd_valid = 0.
- Reset (rst_n = 0 at posedge):
  - Every counter resets to weakly-not-taken, 2^(CNT_BITS-1)-1. For CNT_BITS = 1 this is 0.
  - ghr = 0; perf counters = 0.
  - Pending updates in the same cycle are discarded.
  - Reset takes priority mid-operation.
- Output values after reset:
  - pred_taken = 0.
  - pred_index = if_pc[INDEX_BITS+1:2].
  - perf outputs = 0.

Test Plan:
1. Reset then BEQ at if_pc = 0x40, MODE 0 -> pred_index = 0, pred_taken = 0; table entries all read 2'b01.
2. Two upd_valid pulses on index 3 with upd_taken = 1, then BNE at if_pc = 0x0C -> pred_taken = 1 (cnt = 3). A third taken pulse saturates at 3. Two not-taken pulses are needed before pred_taken = 0.
3. Same-cycle update and lookup on index 5, with cnt = 1 and upd_taken = 1 -> pred_taken = 0 that cycle, 1 the next cycle. stall = 1 or an ADD opcode forces pred_taken = 0.
4. MODE 1: updates with taken, taken, not-taken -> ghr = 4'b0110. Then BEQ at if_pc = 0x0C (pc bits = 3) -> pred_index = 4'b0101.
5. CNT_BITS = 1 -> a single not-taken update after a taken update flips the prediction to 0.
6. PERF_BITS = 4: 20 upd_valid pulses, every 2nd with upd_mispredict -> perf_branches = 15 (saturated), perf_mispredicts = 10. Mid-sequence reset -> both return to 0 and the table returns to weakly-not-taken.

Source files
------------

// File: rtl/branch_predict_bht_if.sv
// branch_predict_bht_if: IF-stage lookup, EX-stage update and statistics signals of the branch predictor
//    master: pipeline side; drives stall/if_pc/if_opcode/upd_*, receives pred_*/perf_*
//    slave : predictor side
interface branch_predict_bht_if #(
   parameter int INDEX_BITS = 4,
   parameter int PERF_BITS  = 16
);
   logic                  stall;
   logic [31:0]           if_pc;
   logic [5:0]            if_opcode;
   logic                  pred_taken;
   logic [INDEX_BITS-1:0] pred_index;
   logic                  upd_valid;
   logic [INDEX_BITS-1:0] upd_index;
   logic                  upd_taken;
   logic                  upd_mispredict;
   logic [PERF_BITS-1:0]  perf_branches;
   logic [PERF_BITS-1:0]  perf_mispredicts;
   modport master (
      output stall, if_pc, if_opcode, upd_valid, upd_index, upd_taken, upd_mispredict,
      input  pred_taken, pred_index, perf_branches, perf_mispredicts
   );
   modport slave (
      input  stall, if_pc, if_opcode, upd_valid, upd_index, upd_taken, upd_mispredict,
      output pred_taken, pred_index, perf_branches, perf_mispredicts
   );
endinterface

// File: rtl/branch_predict_bht.sv
// branch_predict_bht: table of saturating counters, bimodal or gshare indexed, with branch statistics
//    clk, rst_n : clock, synchronous active-low reset
//    b (slave)  : combinational IF lookup (pred_taken/pred_index), registered EX update, perf counters
module branch_predict_bht #(
   parameter int INDEX_BITS = 4,
   parameter int CNT_BITS   = 2,
   parameter int MODE       = 0,
   parameter int PERF_BITS  = 16
) (
   input logic                 clk,
   input logic                 rst_n,
   branch_predict_bht_if.slave b
);
   localparam int N = 1 << INDEX_BITS;
   localparam logic [CNT_BITS-1:0] CNT_RST = CNT_BITS'((1 << (CNT_BITS - 1)) - 1);
   logic [CNT_BITS-1:0]   cnt_q [N];
   logic [CNT_BITS-1:0]   cur, cnt_d;
   logic [INDEX_BITS-1:0] ghr_q, ghr_d, idx;
   logic [PERF_BITS-1:0]  br_q, br_d, mp_q, mp_d;
   logic                  is_br, unused_pc;
   assign unused_pc = ^{b.if_pc[31:INDEX_BITS+2], b.if_pc[1:0]};
   // ghr stays zero in bimodal mode, so the XOR reduces to plain PC indexing
   assign idx = b.if_pc[INDEX_BITS+1:2] ^ ghr_q;
   assign is_br = b.if_opcode == 6'b000100 || b.if_opcode == 6'b000101;
   assign b.pred_index = idx;
   assign b.pred_taken = is_br && !b.stall && cnt_q[idx][CNT_BITS-1];
   assign b.perf_branches = br_q;
   assign b.perf_mispredicts = mp_q;
   always_comb begin
      cur = cnt_q[b.upd_index];
      cnt_d = b.upd_taken ? (cur == '1 ? cur : cur + 1'b1) : (cur == '0 ? cur : cur - 1'b1);
      // truncating {ghr, taken} shifts the outcome in and drops the oldest bit, also for one-bit history
      ghr_d = (MODE == 1 && b.upd_valid) ? INDEX_BITS'({ghr_q, b.upd_taken}) : ghr_q;
      br_d = (b.upd_valid && br_q != '1) ? br_q + 1'b1 : br_q;
      mp_d = (b.upd_valid && b.upd_mispredict && mp_q != '1) ? mp_q + 1'b1 : mp_q;
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < N; i++) cnt_q[i] <= CNT_RST;
         ghr_q <= '0;
         br_q <= '0;
         mp_q <= '0;
      end else begin
         if (b.upd_valid) cnt_q[b.upd_index] <= cnt_d;
         ghr_q <= ghr_d;
         br_q <= br_d;
         mp_q <= mp_d;
      end
   end
endmodule

// File: tb/tb_branch_predict_bht.sv
// tb_branch_predict_bht: four predictor configurations driven in lockstep and compared against a reference model
module tb_branch_predict_bht;
   localparam int K = 4;
   logic clk = 0, rst_n = 0;
   logic stall, upd_valid, upd_taken, upd_mispredict;
   logic [31:0] if_pc;
   logic [5:0] if_opcode;
   logic [3:0] upd_index;
   logic [31:0] o_pt [K], o_pi [K], o_pb [K], o_pm [K];
   int checks = 0, failures = 0;
   int mcnt [K][16];
   int mghr [K], mpb [K], mpm [K];

   always #5 clk = ~clk;

   function automatic int cbits(int k); return k == 2 ? 1 : 2; endfunction
   function automatic int mode(int k); return k == 1 ? 1 : 0; endfunction
   function automatic int pbits(int k); return k == 3 ? 4 : 16; endfunction

   for (genvar g = 0; g < K; g++) begin : g_dut
      localparam int CB = g == 2 ? 1 : 2;
      localparam int MD = g == 1 ? 1 : 0;
      localparam int PB = g == 3 ? 4 : 16;
      branch_predict_bht_if #(.INDEX_BITS(4), .PERF_BITS(PB)) bi ();
      assign bi.stall = stall;
      assign bi.if_pc = if_pc;
      assign bi.if_opcode = if_opcode;
      assign bi.upd_valid = upd_valid;
      assign bi.upd_index = upd_index;
      assign bi.upd_taken = upd_taken;
      assign bi.upd_mispredict = upd_mispredict;
      assign o_pt[g] = 32'(bi.pred_taken);
      assign o_pi[g] = 32'(bi.pred_index);
      assign o_pb[g] = 32'(bi.perf_branches);
      assign o_pm[g] = 32'(bi.perf_mispredicts);
      branch_predict_bht #(.INDEX_BITS(4), .CNT_BITS(CB), .MODE(MD), .PERF_BITS(PB)) u_dut (
         .clk(clk), .rst_n(rst_n), .b(bi.slave)
      );
   end

   task automatic chk(string tag, int k, logic [31:0] o, logic [31:0] e);
      checks++;
      assert (o === e) else begin
         failures++;
         $error("FAIL %s[%0d] got=%0d exp=%0d", tag, k, o, e);
      end
   endtask

   function automatic int m_idx(int k);
      return ((if_pc >> 2) & 15) ^ (mode(k) == 1 ? mghr[k] : 0);
   endfunction

   function automatic int m_pred(int k);
      bit br = if_opcode == 6'd4 || if_opcode == 6'd5;
      return (br && !stall && mcnt[k][m_idx(k)] >= (1 << (cbits(k) - 1))) ? 1 : 0;
   endfunction

   task automatic model_update();
      for (int k = 0; k < K; k++) begin
         int cmax = (1 << cbits(k)) - 1, pmax = (1 << pbits(k)) - 1;
         if (!rst_n) begin
            for (int i = 0; i < 16; i++) mcnt[k][i] = (1 << (cbits(k) - 1)) - 1;
            mghr[k] = 0; mpb[k] = 0; mpm[k] = 0;
         end else if (upd_valid) begin
            int c = mcnt[k][upd_index];
            mcnt[k][upd_index] = upd_taken ? (c < cmax ? c + 1 : c) : (c > 0 ? c - 1 : 0);
            if (mode(k) == 1) mghr[k] = (mghr[k] * 2 + int'(upd_taken)) % 16;
            if (mpb[k] < pmax) mpb[k]++;
            if (upd_mispredict && mpm[k] < pmax) mpm[k]++;
         end
      end
   endtask

   task automatic drive(logic [31:0] pc, logic [5:0] op, logic st, logic uv, logic [3:0] ui, logic ut, logic um);
      if_pc = pc; if_opcode = op; stall = st;
      upd_valid = uv; upd_index = ui; upd_taken = ut; upd_mispredict = um;
      #1;
   endtask

   task automatic check_all();
      for (int k = 0; k < K; k++) begin
         chk("pred_taken", k, o_pt[k], 32'(m_pred(k)));
         chk("pred_index", k, o_pi[k], 32'(m_idx(k)));
         chk("perf_branches", k, o_pb[k], 32'(mpb[k]));
         chk("perf_mispredicts", k, o_pm[k], 32'(mpm[k]));
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_update();
      @(negedge clk);
   endtask

   task automatic upd(logic [3:0] ui, logic ut, logic um);
      drive(0, 0, 0, 1, ui, ut, um);
      check_all();
      tick();
   endtask

   task automatic do_reset();
      rst_n = 0;
      drive(0, 0, 0, 0, 0, 0, 0);
      tick();
      rst_n = 1;
   endtask

   initial begin
      do_reset();
      // 1: reset state, bimodal index, every entry weakly not-taken
      drive(32'h40, 6'd4, 0, 0, 0, 0, 0);
      check_all();
      chk("t1_index", 0, o_pi[0], 0);
      chk("t1_pred", 0, o_pt[0], 0);
      for (int i = 0; i < 16; i++) begin
         drive(32'(i * 4), 6'd4, 0, 0, 0, 0, 0);
         check_all();
         chk("t1_entry_nt", 0, o_pt[0], 0);
         tick();
      end
      // 2: saturating up, two steps down needed
      do_reset();
      upd(3, 1, 0);
      upd(3, 1, 0);
      drive(32'h0C, 6'd5, 0, 0, 0, 0, 0);
      check_all();
      chk("t2_taken", 0, o_pt[0], 1);
      tick();
      upd(3, 1, 0);
      upd(3, 0, 0);
      drive(32'h0C, 6'd5, 0, 0, 0, 0, 0);
      chk("t2_still_taken", 0, o_pt[0], 1);
      tick();
      upd(3, 0, 0);
      drive(32'h0C, 6'd5, 0, 0, 0, 0, 0);
      check_all();
      chk("t2_not_taken", 0, o_pt[0], 0);
      tick();
      // 3: same-cycle read/write sees the old value; stall and non-branch suppress
      drive(32'h14, 6'd4, 0, 1, 5, 1, 0);
      check_all();
      chk("t3_same_cycle", 0, o_pt[0], 0);
      tick();
      drive(32'h14, 6'd4, 0, 0, 0, 0, 0);
      check_all();
      chk("t3_next_cycle", 0, o_pt[0], 1);
      drive(32'h14, 6'd4, 1, 0, 0, 0, 0);
      check_all();
      chk("t3_stall", 0, o_pt[0], 0);
      drive(32'h14, 6'd0, 0, 0, 0, 0, 0);
      check_all();
      chk("t3_add", 0, o_pt[0], 0);
      tick();
      // 4: gshare history
      do_reset();
      upd(0, 1, 0);
      upd(0, 1, 0);
      upd(0, 0, 0);
      drive(32'h0C, 6'd4, 0, 0, 0, 0, 0);
      check_all();
      chk("t4_gshare_idx", 1, o_pi[1], 5);
      tick();
      // 5: one-bit counters flip on each outcome
      do_reset();
      upd(7, 1, 0);
      drive(32'h1C, 6'd4, 0, 0, 0, 0, 0);
      chk("t5_1bit_taken", 2, o_pt[2], 1);
      tick();
      upd(7, 0, 0);
      drive(32'h1C, 6'd4, 0, 0, 0, 0, 0);
      chk("t5_1bit_flip", 2, o_pt[2], 0);
      tick();
      // 6: perf saturation, then reset with an update pending
      do_reset();
      for (int i = 0; i < 20; i++) upd(4'(i), 1, 1'(i % 2));
      drive(0, 0, 0, 0, 0, 0, 0);
      check_all();
      chk("t6_br_sat", 3, o_pb[3], 15);
      chk("t6_mp", 3, o_pm[3], 10);
      chk("t6_br_wide", 0, o_pb[0], 20);
      rst_n = 0;
      drive(0, 0, 0, 1, 2, 1, 1);
      tick();
      rst_n = 1;
      drive(32'h08, 6'd4, 0, 0, 0, 0, 0);
      check_all();
      chk("t6_rst_br", 3, o_pb[3], 0);
      chk("t6_rst_mp", 3, o_pm[3], 0);
      chk("t6_rst_pred", 0, o_pt[0], 0);
      tick();
      // randomized traffic
      for (int n = 0; n < 600; n++) begin
         int r = $urandom_range(0, 3);
         rst_n = $urandom_range(0, 63) != 0;
         drive(32'($urandom_range(0, 255)), r == 0 ? 6'd4 : r == 1 ? 6'd5 : 6'($urandom_range(0, 63)),
               $urandom_range(0, 7) == 0, 1'($urandom), 4'($urandom), 1'($urandom), 1'($urandom));
         check_all();
         tick();
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
